// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD types, converter FSM states and the all-nines limit for a digit count
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  typedef logic [3:0] bcd_digit_t;
  function automatic int unsigned max_val(input int unsigned digits);
    int unsigned r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction
endpackage

// File: rtl/bin_to_bcd_add3.sv
// bcd_add3: double-dabble nibble correction (a >= 5 ? a + 3 : a); ports a (digit in), y (corrected digit)
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  output bcd_digit_t y
);
  always_comb y = (a >= 4'd5) ? a + 4'd3 : a;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: shift-and-add-3 binary-to-BCD, one bit/clk; start/busy/done handshake, clamped bcd_out + ovf
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);
  localparam int unsigned MAX_VAL = max_val(DIGITS);
  localparam int BW = 4 * DIGITS;
  localparam int TW = BW + IN_W;
  localparam int CW = $clog2(IN_W + 1);
  bcd_state_t state_q, state_d;
  logic [IN_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0] work_q, work_d, adj, bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_nx_q, ovf_nx_d, ovf_q, ovf_d, done_q, done_d, busy_q, busy_d, over;
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.a(work_q[4*i +: 4]), .y(adj[4*i +: 4]));
  end
  always_comb begin
    over = 32'(bin_in) > MAX_VAL;
    state_d = state_q;
    shreg_d = shreg_q;
    work_d = work_q;
    cnt_d = cnt_q;
    ovf_nx_d = ovf_nx_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = SHIFT;
      shreg_d = over ? IN_W'(MAX_VAL) : bin_in;
      work_d = '0;
      ovf_nx_d = over;
      cnt_d = CW'(IN_W);
    end else if (state_q == SHIFT) begin
      {work_d, shreg_d} = TW'({adj, shreg_q} << 1);
      cnt_d = cnt_q - CW'(1);
      state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      done_d = 1'b1;
      bcd_d = work_q;
      ovf_d = ovf_nx_q;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      work_q <= '0;
      cnt_q <= '0;
      ovf_nx_q <= 1'b0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      ovf_nx_q <= ovf_nx_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd_out = bcd_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed table-driven bench for bin_to_bcd_seq at default parameters
module tb_bin_to_bcd_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done, ovf;
  logic [13:0] bin_in = '0;
  logic [15:0] bcd_out;
  int checks = 0, errors = 0;
  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;
  vec_t vecs [10];
  bin_to_bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic run(input logic [13:0] v, input logic [15:0] eb, input logic eo);
    int n, b;
    bin_in = v;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    b = 0;
    while (!done && n < 40) begin
      b += int'(busy);
      tick;
      n++;
    end
    chk($sformatf("latency[%0d]", v), n, 15);
    chk($sformatf("busy_cycles[%0d]", v), b, 15);
    chk($sformatf("bcd[%0d]", v), bcd_out, eb);
    chk($sformatf("ovf[%0d]", v), ovf, eo);
    chk($sformatf("busy_at_done[%0d]", v), busy, 0);
    tick;
    chk($sformatf("done_pulse[%0d]", v), done, 0);
  endtask
  initial begin
    int n, seen;
    vecs[0] = '{14'd8,     16'h0008, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9,     16'h0009, 1'b0};
    vecs[3] = '{14'd10,    16'h0010, 1'b0};
    vecs[4] = '{14'd99,    16'h0099, 1'b0};
    vecs[5] = '{14'd100,   16'h0100, 1'b0};
    vecs[6] = '{14'd9999,  16'h9999, 1'b0};
    vecs[7] = '{14'd12345, 16'h9999, 1'b1};
    vecs[8] = '{14'd16,    16'h0016, 1'b0};
    vecs[9] = '{14'd10000, 16'h9999, 1'b1};
    rst = 1'b1;
    start = 1'b1;
    bin_in = 14'd5;
    repeat (3) tick;
    rst = 1'b0;
    start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_ovf", ovf, 0);
    seen = 0;
    repeat (20) begin
      tick;
      seen += int'(done);
    end
    chk("rst_start_dropped", seen, 0);
    foreach (vecs[i]) run(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
    bin_in = 14'd1234;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    bin_in = 14'd77;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 5;
    while (!done && n < 40) begin
      tick;
      n++;
    end
    chk("ignored_start_latency", n, 15);
    chk("ignored_start_bcd", bcd_out, 16'h1234);
    seen = 0;
    repeat (20) begin
      tick;
      seen += int'(busy) + int'(done);
    end
    chk("ignored_start_not_queued", seen, 0);
    bin_in = 14'd4321;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd_out, 16'h0000);
    seen = 0;
    repeat (20) begin
      tick;
      seen += int'(done);
    end
    chk("abort_no_done", seen, 0);
    run(14'd1234, 16'h1234, 1'b0);
    bin_in = 14'd42;
    start = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      tick;
      n++;
    end
    chk("b2b_first_done", done, 1);
    tick;
    n = 1;
    while (!done && n < 40) begin
      tick;
      n++;
    end
    start = 1'b0;
    chk("b2b_period", n, 16);
    chk("b2b_bcd", bcd_out, 16'h0042);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
